// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// FSM state encoding, grant codes and a grant decode helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_LD = 2'd0;
    localparam logic [1:0] GNT_EX = 2'd1;
    localparam logic [1:0] GNT_IF = 2'd2;

    // Bit order matches the requester vector: [0]=ld, [1]=ex, [2]=if
    function automatic logic [2:0] gnt_onehot(input logic [1:0] gnt);
        logic [2:0] v;
        v = 3'b000;
        case (gnt)
            GNT_LD:  v = 3'b001;
            GNT_EX:  v = 3'b010;
            GNT_IF:  v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Fixed-priority 3-to-2 encoder: ld > ex > if.
// Request vector order is [0]=ld, [1]=ex, [2]=if.
module arb_prio_enc
    import mem_bus_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_gnt   = GNT_LD;
        if (i_req[0]) begin
            o_gnt = GNT_LD;
        end else if (i_req[1]) begin
            o_gnt = GNT_EX;
        end else if (i_req[2]) begin
            o_gnt = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory port between loader, execute and fetch.
// One latched command in flight; every access bounded by a timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mld_req_i,
    input  logic              mld_we_i,
    input  logic [3:0]        mld_sel_i,
    input  logic [ADDR_W-1:0] mld_addr_i,
    input  logic [DATA_W-1:0] mld_wdata_i,
    output logic [DATA_W-1:0] mld_rdata_o,
    output logic              mld_ack_o,

    input  logic              mex_req_i,
    input  logic              mex_we_i,
    input  logic [3:0]        mex_sel_i,
    input  logic [ADDR_W-1:0] mex_addr_i,
    input  logic [DATA_W-1:0] mex_wdata_i,
    output logic [DATA_W-1:0] mex_rdata_o,
    output logic              mex_ack_o,

    input  logic              mif_req_i,
    input  logic              mif_we_i,
    input  logic [3:0]        mif_sel_i,
    input  logic [ADDR_W-1:0] mif_addr_i,
    input  logic [DATA_W-1:0] mif_wdata_i,
    output logic [DATA_W-1:0] mif_rdata_o,
    output logic              mif_ack_o,

    output logic              s_req_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,

    output logic              hold_flag_o,
    output logic              bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        r_state;
    logic [1:0]        r_gnt;
    logic              r_sreq;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_ack;
    logic              r_berr;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_gnt;
    logic              w_valid;
    logic              w_we;
    logic [3:0]        w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    arb_prio_enc u_prio (
        .i_req   ({mif_req_i, mex_req_i, mld_req_i}),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    always_comb begin
        w_we    = mld_we_i;
        w_sel   = mld_sel_i;
        w_addr  = mld_addr_i;
        w_wdata = mld_wdata_i;
        case (w_gnt)
            GNT_EX: begin
                w_we    = mex_we_i;
                w_sel   = mex_sel_i;
                w_addr  = mex_addr_i;
                w_wdata = mex_wdata_i;
            end
            GNT_IF: begin
                w_we    = mif_we_i;
                w_sel   = mif_sel_i;
                w_addr  = mif_addr_i;
                w_wdata = mif_wdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= GNT_LD;
            r_sreq  <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= '0;
            r_berr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= w_gnt;
                        r_we    <= w_we;
                        r_sel   <= w_sel;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_sreq  <= 1'b1;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (s_ack_i) begin
                        // Writes return zero so stale bus data never leaks
                        r_rdata <= r_we ? '0 : s_rdata_i;
                        r_ack   <= gnt_onehot(r_gnt);
                        r_sreq  <= 1'b0;
                        r_state <= ARB_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= '0;
                        r_ack   <= gnt_onehot(r_gnt);
                        r_berr  <= 1'b1;
                        r_sreq  <= 1'b0;
                        r_state <= ARB_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARB_RESP: begin
                    r_rdata <= '0;
                    r_ack   <= '0;
                    r_berr  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_sreq  <= 1'b0;
                    r_ack   <= '0;
                    r_berr  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign s_req_o   = r_sreq;
    assign s_we_o    = r_we;
    assign s_sel_o   = r_sel;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign bus_err_o = r_berr;

    assign mld_ack_o = r_ack[0];
    assign mex_ack_o = r_ack[1];
    assign mif_ack_o = r_ack[2];

    assign mld_rdata_o = {DATA_W{r_ack[0]}} & r_rdata;
    assign mex_rdata_o = {DATA_W{r_ack[1]}} & r_rdata;
    assign mif_rdata_o = {DATA_W{r_ack[2]}} & r_rdata;

    // The loader never stalls the pipeline
    assign hold_flag_o = (mex_req_i & ~mex_ack_o)
                       | (mif_req_i & ~mif_ack_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table
// plus a hand-written timeout sequence.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mld_req_i, mld_we_i;
    logic [3:0]  mld_sel_i;
    logic [31:0] mld_addr_i, mld_wdata_i, mld_rdata_o;
    logic        mld_ack_o;
    logic        mex_req_i, mex_we_i;
    logic [3:0]  mex_sel_i;
    logic [31:0] mex_addr_i, mex_wdata_i, mex_rdata_o;
    logic        mex_ack_o;
    logic        mif_req_i, mif_we_i;
    logic [3:0]  mif_sel_i;
    logic [31:0] mif_addr_i, mif_wdata_i, mif_rdata_o;
    logic        mif_ack_o;
    logic        s_req_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic        s_ack_i;
    logic        hold_flag_o, bus_err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mld_req_i   (mld_req_i),
        .mld_we_i    (mld_we_i),
        .mld_sel_i   (mld_sel_i),
        .mld_addr_i  (mld_addr_i),
        .mld_wdata_i (mld_wdata_i),
        .mld_rdata_o (mld_rdata_o),
        .mld_ack_o   (mld_ack_o),
        .mex_req_i   (mex_req_i),
        .mex_we_i    (mex_we_i),
        .mex_sel_i   (mex_sel_i),
        .mex_addr_i  (mex_addr_i),
        .mex_wdata_i (mex_wdata_i),
        .mex_rdata_o (mex_rdata_o),
        .mex_ack_o   (mex_ack_o),
        .mif_req_i   (mif_req_i),
        .mif_we_i    (mif_we_i),
        .mif_sel_i   (mif_sel_i),
        .mif_addr_i  (mif_addr_i),
        .mif_wdata_i (mif_wdata_i),
        .mif_rdata_o (mif_rdata_o),
        .mif_ack_o   (mif_ack_o),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_sel_o     (s_sel_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack_i),
        .hold_flag_o (hold_flag_o),
        .bus_err_o   (bus_err_o)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        ex_we;
        logic [3:0]  ex_sel;
        logic        ack;
        logic [31:0] rd;
        logic        e_sreq;
        logic [2:0]  e_ack;
        logic [31:0] e_rd;
        logic        e_hold;
        logic        e_err;
        logic        chk_a;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(
        input logic rst_v, input logic [2:0] req,
        input logic we, input logic [3:0] sel,
        input logic ack, input logic [31:0] rd,
        input logic e_sreq, input logic [2:0] e_ack,
        input logic [31:0] e_rd, input logic e_hold,
        input logic e_err, input logic chk_a,
        input logic [31:0] e_addr, input logic [3:0] e_sel);
        vec_t v;
        v.rst = rst_v; v.req = req; v.ex_we = we; v.ex_sel = sel;
        v.ack = ack; v.rd = rd; v.e_sreq = e_sreq; v.e_ack = e_ack;
        v.e_rd = e_rd; v.e_hold = e_hold; v.e_err = e_err;
        v.chk_a = chk_a; v.e_addr = e_addr; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h",
                     nm, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst       = v.rst;
        mld_req_i = v.req[0];
        mex_req_i = v.req[1];
        mif_req_i = v.req[2];
        mex_we_i  = v.ex_we;
        mex_sel_i = v.ex_sel;
        s_ack_i   = v.ack;
        s_rdata_i = v.rd;
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk("s_req", i, 32'(s_req_o), 32'(v.e_sreq));
        chk("acks", i, 32'({mif_ack_o, mex_ack_o, mld_ack_o}),
            32'(v.e_ack));
        chk("ld_rdata", i, mld_rdata_o, v.e_ack[0] ? v.e_rd : 32'h0);
        chk("ex_rdata", i, mex_rdata_o, v.e_ack[1] ? v.e_rd : 32'h0);
        chk("if_rdata", i, mif_rdata_o, v.e_ack[2] ? v.e_rd : 32'h0);
        chk("hold", i, 32'(hold_flag_o), 32'(v.e_hold));
        chk("bus_err", i, 32'(bus_err_o), 32'(v.e_err));
        if (v.chk_a) begin
            chk("s_addr", i, s_addr_o, v.e_addr);
            chk("s_sel", i, 32'(s_sel_o), 32'(v.e_sel));
        end
    endtask

    initial begin
        int lat;
        bit early;

        // Reset: hold follows req even while rst is high
        q.push_back(mk(1,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 1,32'h0,4'h0));
        q.push_back(mk(1,3'b010,0,4'hF,0,0, 0,3'b000,0,1,0, 1,32'h0,4'h0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 1,32'h0,4'h0));
        // Single ex read, zero-wait
        q.push_back(mk(0,3'b010,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b010,0,4'hF,1,32'hDEADBEEF,
                       1,3'b000,0,1,0, 1,32'h100,4'hF));
        q.push_back(mk(0,3'b010,0,4'hF,0,0,
                       0,3'b010,32'hDEADBEEF,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        // ld alone never raises hold; write returns 0
        q.push_back(mk(0,3'b001,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b001,0,4'hF,1,32'h0F0F0F0F,
                       1,3'b000,0,0,0, 1,32'h200,4'hF));
        q.push_back(mk(0,3'b001,0,4'hF,0,0, 0,3'b001,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        // All three at once: ld, ex, if at 2, 5, 8
        q.push_back(mk(0,3'b111,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b111,0,4'hF,1,32'hAAAA5555,
                       1,3'b000,0,1,0, 1,32'h200,4'hF));
        q.push_back(mk(0,3'b111,0,4'hF,0,0, 0,3'b001,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b110,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b110,0,4'hF,1,32'h12345678,
                       1,3'b000,0,1,0, 1,32'h100,4'hF));
        q.push_back(mk(0,3'b110,0,4'hF,0,0,
                       0,3'b010,32'h12345678,1,0, 0,0,0));
        q.push_back(mk(0,3'b100,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b100,0,4'hF,1,32'hCAFEF00D,
                       1,3'b000,0,1,0, 1,32'h300,4'hF));
        q.push_back(mk(0,3'b100,0,4'hF,0,0,
                       0,3'b100,32'hCAFEF00D,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        // ex sb, sel 0100, three wait cycles
        q.push_back(mk(0,3'b010,1,4'h4,0,0, 0,3'b000,0,1,0, 0,0,0));
        for (int k = 0; k < 3; k++)
            q.push_back(mk(0,3'b010,1,4'h4,0,0,
                           1,3'b000,0,1,0, 1,32'h100,4'h4));
        q.push_back(mk(0,3'b010,1,4'h4,1,32'h55555555,
                       1,3'b000,0,1,0, 1,32'h100,4'h4));
        q.push_back(mk(0,3'b010,1,4'h4,0,0, 0,3'b010,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        // rst in 2nd BUSY cycle of a fetch, then re-arbitration
        q.push_back(mk(0,3'b100,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b100,0,4'hF,0,0,
                       1,3'b000,0,1,0, 1,32'h300,4'hF));
        q.push_back(mk(1,3'b100,0,4'hF,0,0, 1,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b100,0,4'hF,0,0,
                       0,3'b000,0,1,0, 1,32'h0,4'h0));
        q.push_back(mk(0,3'b100,0,4'hF,1,32'h0BADF00D,
                       1,3'b000,0,1,0, 1,32'h300,4'hF));
        q.push_back(mk(0,3'b100,0,4'hF,0,0,
                       0,3'b100,32'h0BADF00D,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));
        // Spurious acks outside BUSY; ex drops req mid-access
        q.push_back(mk(0,3'b000,0,4'hF,1,32'hFFFFFFFF,
                       0,3'b000,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,1,32'hFFFFFFFF,
                       0,3'b000,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b010,0,4'hF,0,0, 0,3'b000,0,1,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0,
                       1,3'b000,0,0,0, 1,32'h100,4'hF));
        q.push_back(mk(0,3'b000,0,4'hF,1,32'h13579BDF,
                       1,3'b000,0,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,1,32'hFFFFFFFF,
                       0,3'b010,32'h13579BDF,0,0, 0,0,0));
        q.push_back(mk(0,3'b000,0,4'hF,0,0, 0,3'b000,0,0,0, 0,0,0));

        rst         = 1'b1;
        mld_req_i   = 0; mld_we_i = 1; mld_sel_i = 4'hF;
        mld_addr_i  = 32'h200; mld_wdata_i = 32'h11111111;
        mex_req_i   = 0; mex_we_i = 0; mex_sel_i = 4'hF;
        mex_addr_i  = 32'h100; mex_wdata_i = 32'h22222222;
        mif_req_i   = 0; mif_we_i = 0; mif_sel_i = 4'hF;
        mif_addr_i  = 32'h300; mif_wdata_i = 32'h0;
        s_ack_i     = 0; s_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            @(negedge clk);
            check_row(i, q[i]);
            @(posedge clk);
            #1;
        end

        // Timeout: memory never acks
        rst = 0; s_ack_i = 0; s_rdata_i = 32'hFFFFFFFF;
        mex_req_i = 1; mex_we_i = 0; mex_sel_i = 4'hF;
        lat = -1;
        early = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (mex_ack_o) begin
                lat = n;
                break;
            end
            if (bus_err_o) early = 1;
        end
        chk("tmo_latency", 0, 32'(lat), 32'd17);
        chk("tmo_early_err", 0, 32'(early), 32'd0);
        chk("tmo_err", 0, 32'(bus_err_o), 32'd1);
        chk("tmo_rdata", 0, mex_rdata_o, 32'h0);
        chk("tmo_sreq", 0, 32'(s_req_o), 32'd0);
        mex_req_i = 0;
        @(posedge clk);
        #1;
        chk("tmo_idle_ack", 1, 32'(mex_ack_o), 32'd0);
        chk("tmo_idle_err", 1, 32'(bus_err_o), 32'd0);
        @(posedge clk);
        #1;
        chk("tmo_idle_sreq", 2, 32'(s_req_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the single data-memory port between three requesters: the load/store path of the execute stage (ex), instruction fetch (if) and the program loader (ld). It latches one command at a time, drives it to memory with a req/ack handshake and returns read data to the requester. It raises a pipeline hold to the controller while ex or if is waiting. It also bounds every access with a timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max BUSY cycles waiting for s_ack_i (≥2)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  reset, active-high, synchronous
- mX_req_i  in  1  request, where X ∈ {ld, ex, if}
- mX_we_i  in  1  1=write
- mX_sel_i  in  4  byte enables
- mX_addr_i  in  ADDR_W  address
- mX_wdata_i  in  DATA_W  write data
- mX_rdata_o  out  DATA_W  read data, valid with mX_ack_o
- mX_ack_o  out  1  one-cycle completion pulse
- s_req_o  out  1  memory request
- s_we_o  out  1  write enable
- s_sel_o  out  4  byte enables
- s_addr_o  out  ADDR_W  address
- s_wdata_o  out  DATA_W  write data
- s_rdata_i  in  DATA_W  read data, valid with s_ack_i
- s_ack_i  in  1  memory completion
- hold_flag_o  out  1  to ctrl: stall pipeline
- bus_err_o  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Fixed priority ld > ex > if.
  - If any req is high: latch grant index, we, sel, addr and wdata of the winner, clear the timeout counter, go to BUSY.
  - If no req is high, stay in IDLE.
- BUSY:
  - s_req_o=1; s_* driven only from the latched copy. Requester inputs are ignored.
  - On s_ack_i: latch s_rdata_i (write: latch 0), go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 without ack: latch rdata=0, set the error flag, go to RESP.
- RESP:
  - mG_ack_o=1 for the granted master G; mG_rdata_o=latched data; bus_err_o=1 if the error flag is set.
  - Go to IDLE. No arbitration happens in RESP.
- Requesters hold req and command stable until ack. A req dropped after the grant does not abort the access; the ack pulse is still issued.
- Non-granted mX_ack_o=0 and mX_rdata_o=0.
- hold_flag_o = (mex_req_i & ~mex_ack_o) | (mif_req_i & ~mif_ack_o). This is combinational from the registered ack; ld never holds.
- An ack from memory outside BUSY is ignored.

## Timing
- Reset values: state=IDLE, s_req_o=0, s_we_o=0, s_sel_o=0, s_addr_o=0, s_wdata_o=0, all mX_ack_o=0, all mX_rdata_o=0, bus_err_o=0, counter=0. hold_flag_o follows the req inputs.
- rst during BUSY or RESP: next cycle is IDLE with outputs at reset values. The in-flight access is dropped with no ack and no err.
- Zero-wait memory (s_ack_i in the first BUSY cycle): req seen in IDLE at cycle 0, s_req_o at cycle 1, mX_ack_o at cycle 2. Max throughput is one access per 3 cycles.
- Each extra memory wait cycle adds one cycle of latency.
- Timeout: ack with rdata=0 and bus_err_o pulse TIMEOUT+1 cycles after the grant.
- Simultaneous reqs are served in priority order, each separated by the RESP→IDLE bubble.

## Structure
- defines.v gains `ARB_IDLE/`ARB_BUSY/`ARB_RESP (2-bit) and the grant codes `GNT_LD=2'd0, `GNT_EX=2'd1, `GNT_IF=2'd2.
- One sub-module, arb_prio_enc: combinational 3-to-2 fixed-priority encoder producing the grant index and a valid bit.
- The FSM, command latch, counter and response path stay in mem_bus_arbiter.

## Test plan
- Single ex read, addr 0x100, zero-wait memory returning 0xDEADBEEF -> s_req_o at cycle 1, mex_ack_o with rdata 0xDEADBEEF at cycle 2, hold_flag_o high at cycles 0–1 only.
- ex, if and ld requesting simultaneously, each held until ack -> grant order ld, ex, if; three ack pulses at cycles 2, 5, 8; no two acks in the same cycle.
- ex sb, sel 0100, memory acks after 3 wait cycles -> s_sel_o=0100 and address stable for 4 BUSY cycles, mex_ack_o at cycle 5 with rdata 0.
- Memory never acks, TIMEOUT=16 -> mex_ack_o with rdata 0 and bus_err_o pulse together 17 cycles after the grant; FSM back in IDLE.
- rst asserted in the 2nd BUSY cycle of an if fetch -> s_req_o=0 the next cycle, no mif_ack_o, next if req re-arbitrated normally.
- Spurious s_ack_i in IDLE, plus ex dropping req mid-BUSY -> spurious ack ignored; the dropped access still completes with an ack pulse.
